// File: rtl/lcd_pkg.sv
// Shared LCD test-pattern definitions: sequencer FSM states,
// select-width helper and default panel timing constants.
package lcd_pkg;

  typedef enum logic {
    ST_RUN     = 1'b0,
    ST_PENDING = 1'b1
  } seq_state_e;

  localparam int H_ACTIVE = 480;
  localparam int H_FP     = 8;
  localparam int H_SYNC   = 4;
  localparam int H_BP     = 43;
  localparam int V_ACTIVE = 272;
  localparam int V_FP     = 4;
  localparam int V_SYNC   = 4;
  localparam int V_BP     = 12;

  localparam int DEF_NUM_PATTERNS = 4;

  function automatic int sel_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Push-button conditioner: 2-FF synchronizer, stable-level debounce counter, press pulse.
// Ports: clk, rst_n (async low), btn_n (raw, active low), press (1-cycle pulse on accepted press).
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 270000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_n,
  output logic press
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic          s1;
  logic          s2;
  logic          stable;
  logic [CW-1:0] cnt;
  logic          flip;

  // Nth consecutive differing sample flips the stable level
  assign flip = (s2 != stable) && (cnt == CNT_MAX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1     <= 1'b1;
      s2     <= 1'b1;
      stable <= 1'b1;
      cnt    <= '0;
      press  <= 1'b0;
    end else begin
      s1    <= btn_n;
      s2    <= s1;
      press <= flip && stable;
      if (s2 == stable) begin
        cnt <= '0;
      end else if (flip) begin
        stable <= s2;
        cnt    <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/pattern_sequencer.sv
// Frame-synchronous pattern selector: advances on button press or auto timer, only at vsync.
// Ports: clk, rst_n, btn_n, auto_en, vsync, de -> pattern_sel, frame_start, frame_cnt, pending, de_err.
module pattern_sequencer
  import lcd_pkg::*;
#(
  parameter int NUM_PATTERNS       = 4,
  parameter int FRAMES_PER_PATTERN = 60,
  parameter int DEBOUNCE_CYCLES    = 270000,
  parameter bit VSYNC_ACTIVE_LOW   = 1'b1,
  parameter int SEL_W              = sel_w(NUM_PATTERNS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             btn_n,
  input  logic             auto_en,
  input  logic             vsync,
  input  logic             de,
  output logic [SEL_W-1:0] pattern_sel,
  output logic             frame_start,
  output logic [7:0]       frame_cnt,
  output logic             pending,
  output logic             de_err
);

  localparam logic VS_ACT = VSYNC_ACTIVE_LOW ? 1'b0 : 1'b1;
  localparam logic [SEL_W-1:0] SEL_LAST = SEL_W'(NUM_PATTERNS - 1);

  seq_state_e       state;
  seq_state_e       state_d;
  logic [SEL_W-1:0] sel_d;
  logic [7:0]       cnt_d;
  logic             vs_q;
  logic             press;
  logic             auto_req;
  logic             do_switch;

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_deb (
    .clk  (clk),
    .rst_n(rst_n),
    .btn_n(btn_n),
    .press(press)
  );

  // >= so that re-enabling auto past the threshold still switches
  assign auto_req = auto_en &&
                    (int'(frame_cnt) >= FRAMES_PER_PATTERN - 1);
  assign pending  = (state == ST_PENDING);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vs_q        <= ~VS_ACT;
      frame_start <= 1'b0;
      de_err      <= 1'b0;
    end else begin
      vs_q        <= vsync;
      // registered boundary: vs_q entering its active level
      frame_start <= (vsync == VS_ACT) && (vs_q != VS_ACT);
      if ((vs_q == VS_ACT) && de)
        de_err <= 1'b1;
    end
  end

  always_comb begin
    state_d   = state;
    sel_d     = pattern_sel;
    cnt_d     = frame_cnt;
    do_switch = 1'b0;
    unique case (state)
      ST_RUN: begin
        if (frame_start) begin
          if (auto_req)
            do_switch = 1'b1;
          else if (frame_cnt != 8'hFF)
            cnt_d = frame_cnt + 8'd1;
        end
        // a press coinciding with a boundary waits for the next one
        if (press)
          state_d = ST_PENDING;
      end
      ST_PENDING: begin
        if (frame_start) begin
          do_switch = 1'b1;
          state_d   = ST_RUN;
        end
      end
    endcase
    if (do_switch) begin
      sel_d = (pattern_sel == SEL_LAST) ? '0 : pattern_sel + 1'b1;
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_RUN;
      pattern_sel <= '0;
      frame_cnt   <= '0;
    end else begin
      state       <= state_d;
      pattern_sel <= sel_d;
      frame_cnt   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_pattern_sequencer.sv
// Self-checking bench for pattern_sequencer: synthetic 20-cycle active-low frames,
// expected (pattern_sel, frame_cnt) per frame_start queued and compared by a monitor.
module tb_pattern_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       btn_n = 1'b1;
  logic       auto_en = 1'b0;
  logic       vsync = 1'b1;
  logic       de = 1'b0;
  logic [1:0] pattern_sel;
  logic       frame_start;
  logic [7:0] frame_cnt;
  logic       pending;
  logic       de_err;

  int n_chk = 0;
  int n_err = 0;
  int fs_count = 0;

  typedef struct {
    int sel;
    int cnt;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  logic fs_seen = 1'b0;
  int   fs_mark;

  pattern_sequencer #(
    .NUM_PATTERNS      (4),
    .FRAMES_PER_PATTERN(3),
    .DEBOUNCE_CYCLES   (4),
    .VSYNC_ACTIVE_LOW  (1'b1),
    .SEL_W             (2)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .btn_n      (btn_n),
    .auto_en    (auto_en),
    .vsync      (vsync),
    .de         (de),
    .pattern_sel(pattern_sel),
    .frame_start(frame_start),
    .frame_cnt  (frame_cnt),
    .pending    (pending),
    .de_err     (de_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // one frame_start seen -> compare state right after the switch edge
  always @(negedge clk) begin
    if (fs_seen) begin
      fs_count++;
      if (sb.size() == 0) begin
        chk("sb_underflow", 32'd1, 32'd0);
      end else begin
        mon_e = sb.pop_front();
        chk("fs_sel", 32'(pattern_sel), mon_e.sel);
        chk("fs_cnt", 32'(frame_cnt), mon_e.cnt);
      end
    end
    fs_seen = frame_start;
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic frame(input int exp_sel, input int exp_cnt);
    exp_t e;
    e.sel = exp_sel;
    e.cnt = exp_cnt;
    sb.push_back(e);
    for (int i = 0; i < 20; i++) begin
      vsync = !(i < 2);
      de    = (i >= 6) && (i < 16);
      @(negedge clk);
    end
    vsync = 1'b1;
    de    = 1'b0;
  endtask

  task automatic async_reset_check(input string tag);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk({tag, "_sel"}, 32'(pattern_sel), 32'd0);
    chk({tag, "_cnt"}, 32'(frame_cnt), 32'd0);
    chk({tag, "_fs"}, 32'(frame_start), 32'd0);
    chk({tag, "_pend"}, 32'(pending), 32'd0);
    chk({tag, "_derr"}, 32'(de_err), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    idle(2);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // reset state
    idle(3);
    chk("rst_sel", 32'(pattern_sel), 32'd0);
    chk("rst_cnt", 32'(frame_cnt), 32'd0);
    chk("rst_fs", 32'(frame_start), 32'd0);
    chk("rst_pend", 32'(pending), 32'd0);
    chk("rst_derr", 32'(de_err), 32'd0);
    rst_n = 1'b1;
    idle(2);

    // count, then async reset mid-frame
    frame(0, 1);
    frame(0, 2);
    idle(5);
    async_reset_check("midrst");
    fs_mark = fs_count;
    for (int f = 1; f <= 5; f++)
      frame(0, f);
    idle(2);
    chk("p1_cnt", 32'(frame_cnt), 32'd5);
    chk("p1_pulses", 32'(fs_count - fs_mark), 32'd5);

    // bouncing button, then held low
    for (int i = 0; i < 20; i++) begin
      btn_n = ((i / 2) % 2) != 0;
      @(negedge clk);
    end
    chk("bounce_pend", 32'(pending), 32'd0);
    btn_n = 1'b0;
    idle(8);
    chk("press_pend", 32'(pending), 32'd1);
    chk("press_sel", 32'(pattern_sel), 32'd0);
    frame(1, 0);
    chk("sw_pend", 32'(pending), 32'd0);
    btn_n = 1'b1;
    idle(10);
    chk("release_pend", 32'(pending), 32'd0);
    frame(1, 1);

    // auto advance from a clean reset
    async_reset_check("rst3");
    auto_en = 1'b1;
    for (int f = 1; f <= 12; f++)
      frame((f % 3 == 0) ? (f / 3) % 4 : f / 3 % 4, f % 3);
    chk("wrap_sel", 32'(pattern_sel), 32'd0);

    // collision: auto due and pending at the same boundary
    frame(0, 1);
    frame(0, 2);
    btn_n = 1'b0;
    idle(8);
    chk("col_pend", 32'(pending), 32'd1);
    frame(1, 0);
    chk("col_pend_clr", 32'(pending), 32'd0);
    btn_n = 1'b1;
    idle(10);
    auto_en = 1'b0;

    // press lands in the frame_start cycle: deferred one frame
    fork
      begin
        repeat (15) @(negedge clk);
        btn_n = 1'b0;
        repeat (12) @(negedge clk);
        btn_n = 1'b1;
      end
    join_none
    frame(1, 1);
    chk("defer_pend0", 32'(pending), 32'd0);
    frame(1, 2);
    chk("defer_pend1", 32'(pending), 32'd1);
    frame(2, 0);
    chk("defer_done", 32'(pending), 32'd0);
    idle(5);

    // de high while vsync active
    begin
      exp_t e;
      e.sel = 2;
      e.cnt = 1;
      sb.push_back(e);
    end
    vsync = 1'b0;
    idle(2);
    chk("derr_pre", 32'(de_err), 32'd0);
    de = 1'b1;
    @(negedge clk);
    de = 1'b0;
    chk("derr_set", 32'(de_err), 32'd1);
    idle(1);
    vsync = 1'b1;
    idle(10);
    frame(2, 2);
    chk("derr_sticky", 32'(de_err), 32'd1);

    // reset while pending discards the request
    btn_n = 1'b0;
    idle(8);
    chk("p6_pend", 32'(pending), 32'd1);
    chk("p6_sel", 32'(pattern_sel), 32'd2);
    btn_n = 1'b1;
    async_reset_check("p6rst");
    idle(10);
    chk("p6_pend_after", 32'(pending), 32'd0);
    frame(0, 1);
    chk("p6_no_switch", 32'(pattern_sel), 32'd0);
    chk("p6_pend_end", 32'(pending), 32'd0);

    idle(4);
    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
